// File: rtl/cas_fsk_player.sv
// Cassette image player: fetches the image in 8-byte groups, replaces each aligned
// header group with a 2400 Hz pilot, and sends all other bytes as framed FSK bits.
module cas_fsk_player #(
  parameter int HALF_1200   = 2237,
  parameter int HALF_2400   = 1119,
  parameter int LONG_PILOT  = 16000,
  parameter int SHORT_PILOT = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_5m3,
  input  logic        play,
  input  logic        rewind,
  input  logic [26:0] cas_size,
  output logic [26:0] ram_a,
  output logic        ram_rd,
  input  logic [7:0]  ram_di,
  input  logic        buff_mem_ready,
  output logic        cas_out,
  output logic        active,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    PILOT = 3'd3,
    SEND  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [15:0] H12_LAST  = 16'(HALF_1200 - 1);
  localparam logic [15:0] H24_LAST  = 16'(HALF_2400 - 1);
  localparam logic [15:0] LONG_CNT  = 16'(LONG_PILOT);
  localparam logic [15:0] SHORT_CNT = 16'(SHORT_PILOT);

  state_t      state_q;
  logic [26:0] base_q;
  logic [26:0] ram_a_q;
  logic        ram_rd_q;
  logic [7:0]  buf_q [8];
  logic [3:0]  fidx_q;
  logic [3:0]  n_q;
  logic        first_hdr_q;
  logic [15:0] tick_q;
  logic [15:0] pilot_q;
  logic [1:0]  half_q;
  logic [3:0]  bit_q;
  logic [2:0]  byte_q;
  logic        cas_out_q;

  logic [26:0] fetch_addr_d;
  logic [26:0] base_send_d;
  logic [26:0] base_pilot_d;
  logic [7:0]  cur_byte_d;
  logic        cur_bit_d;
  logic [15:0] half_last_d;
  logic        half_end_d;
  logic [1:0]  halves_last_d;
  logic        hdr_match_d;

  assign fetch_addr_d = base_q + 27'(fidx_q);
  assign base_send_d  = base_q + 27'(n_q);
  assign base_pilot_d = base_q + 27'd8;

  assign hdr_match_d = (buf_q[0] == 8'h1F) && (buf_q[1] == 8'hA6) &&
                       (buf_q[2] == 8'hDE) && (buf_q[3] == 8'hBA) &&
                       (buf_q[4] == 8'hCC) && (buf_q[5] == 8'h13) &&
                       (buf_q[6] == 8'h7D) && (buf_q[7] == 8'h74);

  // Frame bit 0 is the start bit, 1..8 the data LSB first, 9..10 the stop bits.
  always_comb begin
    cur_byte_d = buf_q[byte_q];
    if (bit_q == 4'd0) cur_bit_d = 1'b0;
    else if (bit_q >= 4'd9) cur_bit_d = 1'b1;
    else cur_bit_d = cur_byte_d[3'(bit_q - 4'd1)];
    half_last_d   = (state_q == PILOT || cur_bit_d) ? H24_LAST : H12_LAST;
    half_end_d    = ce_5m3 && (tick_q == half_last_d);
    halves_last_d = cur_bit_d ? 2'd3 : 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      ram_a_q     <= '0;
      ram_rd_q    <= 1'b0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      fidx_q      <= '0;
      n_q         <= '0;
      first_hdr_q <= 1'b1;
      tick_q      <= '0;
      pilot_q     <= '0;
      half_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      cas_out_q   <= 1'b0;
    end else if (rewind) begin
      state_q     <= IDLE;
      base_q      <= '0;
      ram_a_q     <= '0;
      ram_rd_q    <= 1'b0;
      fidx_q      <= '0;
      n_q         <= '0;
      first_hdr_q <= 1'b1;
      tick_q      <= '0;
      pilot_q     <= '0;
      half_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      cas_out_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            base_q <= '0;
            fidx_q <= '0;
            state_q <= (cas_size != 27'd0) ? FETCH : DONE;
          end
        end
        FETCH: begin
          // An issued read always completes; only new requests wait for play.
          if (ram_rd_q) begin
            if (buff_mem_ready) begin
              buf_q[fidx_q[2:0]] <= ram_di;
              fidx_q   <= fidx_q + 4'd1;
              ram_rd_q <= 1'b0;
            end
          end else if (play) begin
            if (fidx_q == 4'd8 || fetch_addr_d >= cas_size) begin
              n_q     <= fidx_q;
              state_q <= CHECK;
            end else begin
              ram_a_q  <= fetch_addr_d;
              ram_rd_q <= 1'b1;
            end
          end
        end
        CHECK: begin
          if (play) begin
            tick_q    <= '0;
            half_q    <= '0;
            cas_out_q <= 1'b1;
            if (n_q == 4'd8 && base_q[2:0] == 3'd0 && hdr_match_d) begin
              pilot_q <= first_hdr_q ? LONG_CNT : SHORT_CNT;
              state_q <= PILOT;
            end else begin
              bit_q   <= '0;
              byte_q  <= '0;
              state_q <= SEND;
            end
          end
        end
        PILOT: begin
          if (play && half_end_d) begin
            tick_q <= '0;
            if (half_q[0]) begin
              pilot_q <= pilot_q - 16'd1;
              half_q  <= '0;
              if (pilot_q == 16'd1) begin
                cas_out_q   <= 1'b0;
                first_hdr_q <= 1'b0;
                base_q      <= base_pilot_d;
                fidx_q      <= '0;
                state_q     <= (base_pilot_d >= cas_size) ? DONE : FETCH;
              end else begin
                cas_out_q <= 1'b1;
              end
            end else begin
              half_q    <= 2'd1;
              cas_out_q <= 1'b0;
            end
          end else if (play && ce_5m3) begin
            tick_q <= tick_q + 16'd1;
          end
        end
        SEND: begin
          if (play && half_end_d) begin
            tick_q <= '0;
            if (half_q == halves_last_d) begin
              half_q <= '0;
              if (bit_q == 4'd10) begin
                bit_q <= '0;
                if (byte_q == 3'(n_q - 4'd1)) begin
                  cas_out_q <= 1'b0;
                  base_q    <= base_send_d;
                  fidx_q    <= '0;
                  state_q   <= (base_send_d >= cas_size) ? DONE : FETCH;
                end else begin
                  byte_q    <= byte_q + 3'd1;
                  cas_out_q <= 1'b1;
                end
              end else begin
                bit_q     <= bit_q + 4'd1;
                cas_out_q <= 1'b1;
              end
            end else begin
              half_q    <= half_q + 2'd1;
              cas_out_q <= ~cas_out_q;
            end
          end else if (play && ce_5m3) begin
            tick_q <= tick_q + 16'd1;
          end
        end
        DONE: begin
          cas_out_q <= 1'b0;
          ram_rd_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_rd    = ram_rd_q;
  assign cas_out   = cas_out_q;
  assign dbg_state = state_q;
  assign active    = (state_q == FETCH) || (state_q == CHECK) ||
                     (state_q == PILOT) || (state_q == SEND);

endmodule

// File: tb/tb_cas_fsk_player.sv
// Bench for cas_fsk_player: cas_out high/low run lengths and read addresses are
// checked against expectations built from the loaded image.
module tb_cas_fsk_player;

  localparam int T12 = 4;
  localparam int T24 = 2;
  localparam logic [2:0] S_IDLE = 3'd0, S_PILOT = 3'd3, S_SEND = 3'd4, S_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        reset, ce_5m3, play, rewind;
  logic [26:0] cas_size, ram_a;
  logic        ram_rd;
  logic [7:0]  ram_di;
  logic        buff_mem_ready;
  logic        cas_out, active;
  logic [2:0]  dbg_state;

  cas_fsk_player #(
    .HALF_1200(T12), .HALF_2400(T24), .LONG_PILOT(3), .SHORT_PILOT(2)
  ) dut (
    .clk(clk), .reset(reset), .ce_5m3(ce_5m3), .play(play), .rewind(rewind),
    .cas_size(cas_size), .ram_a(ram_a), .ram_rd(ram_rd), .ram_di(ram_di),
    .buff_mem_ready(buff_mem_ready), .cas_out(cas_out), .active(active),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [64];
  logic [7:0]  hdr_bytes [8] = '{8'h1F, 8'hA6, 8'hDE, 8'hBA, 8'hCC, 8'h13, 8'h7D, 8'h74};
  logic [15:0] exp_q[$];     // {exact, level, length}
  logic [26:0] rd_exp_q[$];
  logic        mon_en = 1'b0;
  logic        rd_chk = 1'b0;
  logic        play_s = 1'b0;
  int          rd_count = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_seg(input bit lvl, input int len, input bit exact);
    exp_q.push_back({exact, lvl, 14'(len)});
  endtask

  task automatic build_expected(input int size);
    int  base;
    int  n;
    bit  first;
    bit  hdr;
    logic [7:0] v;
    logic [15:0] last;
    exp_q.delete();
    rd_exp_q.delete();
    base  = 0;
    first = 1'b1;
    while (base < size) begin
      n = (size - base >= 8) ? 8 : size - base;
      for (int i = 0; i < n; i++) rd_exp_q.push_back(27'(base + i));
      hdr = (n == 8) && (base % 8 == 0);
      if (hdr) for (int i = 0; i < 8; i++) if (mem[base + i] != hdr_bytes[i]) hdr = 1'b0;
      if (hdr) begin
        for (int p = 0; p < (first ? 3 : 2); p++) begin
          push_seg(1'b1, T24, 1'b1);
          push_seg(1'b0, T24, 1'b1);
        end
        first = 1'b0;
        base += 8;
      end else begin
        for (int b = 0; b < n; b++) begin
          v = mem[base + b];
          for (int k = 0; k < 11; k++) begin
            if (k == 0 || (k <= 8 && v[k-1] == 1'b0)) begin
              push_seg(1'b1, T12, 1'b1);
              push_seg(1'b0, T12, 1'b1);
            end else begin
              for (int c = 0; c < 2; c++) begin
                push_seg(1'b1, T24, 1'b1);
                push_seg(1'b0, T24, 1'b1);
              end
            end
          end
        end
        base += n;
      end
      // The group's last low stretches through the next fetch.
      last = exp_q[exp_q.size()-1];
      last[15] = 1'b0;
      exp_q[exp_q.size()-1] = last;
    end
    if (exp_q.size() != 0) void'(exp_q.pop_back());
  endtask

  task automatic emit_seg(input logic lvl, input int len);
    logic [15:0] e;
    check("seg_avail", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("seg_lvl", lvl, e[14]);
      if (e[15]) check("seg_len", len, e[13:0]);
      else check("seg_len_min", len >= int'(e[13:0]), 1);
    end
  endtask

  always @(posedge clk) play_s <= play;

  // cas_out run-length monitor; frozen (paused) cycles are not counted
  logic run_started = 1'b0;
  logic run_lvl = 1'b0;
  int   run_len = 0;
  always @(negedge clk) begin
    if (!mon_en) begin
      run_started = 1'b0;
      run_len = 0;
    end else if (play_s) begin
      if (!run_started) begin
        if (cas_out) begin
          run_started = 1'b1;
          run_lvl = 1'b1;
          run_len = 1;
        end
      end else if (cas_out == run_lvl) begin
        run_len++;
      end else begin
        emit_seg(run_lvl, run_len);
        run_lvl = cas_out;
        run_len = 1;
      end
    end
  end

  // memory responder with random 1..5 clk latency
  task automatic serve();
    logic [26:0] a;
    ram_di = mem[ram_a[5:0]];
    buff_mem_ready = 1'b1;
    rd_count++;
    if (rd_chk) begin
      check("rd_lt_size", ram_a < cas_size, 1);
      check("rd_avail", rd_exp_q.size() != 0, 1);
      if (rd_exp_q.size() != 0) begin
        a = rd_exp_q.pop_front();
        check("rd_addr", ram_a, a);
      end
    end
  endtask

  initial begin
    int  cnt;
    bit  pending;
    buff_mem_ready = 1'b0;
    ram_di = '0;
    pending = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (buff_mem_ready) begin
        buff_mem_ready = 1'b0;
        pending = 1'b0;
      end else if (!ram_rd) begin
        pending = 1'b0;
      end else if (!pending) begin
        pending = 1'b1;
        cnt = $urandom_range(1, 5) - 1;
        if (cnt == 0) serve();
      end else begin
        cnt--;
        if (cnt == 0) serve();
      end
    end
  end

  // driver tasks
  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dbg_state == target) break;
    end
    check(tag, dbg_state, target);
  endtask

  task automatic start_image(input int size);
    play = 1'b0;
    cas_size = 27'(size);
    @(posedge clk); #1 rewind = 1'b1;
    @(posedge clk); #1 rewind = 1'b0;
    build_expected(size);
    rd_count = 0;
    rd_chk = 1'b1;
    mon_en = 1'b1;
    play = 1'b1;
  endtask

  task automatic finish_image(input int budget, input string tag);
    wait_state(S_DONE, budget, tag);
    check({tag, "_segs_left"}, exp_q.size(), 0);
    check({tag, "_rds_left"}, rd_exp_q.size(), 0);
    check({tag, "_cas_out"}, cas_out, 0);
    check({tag, "_active"}, active, 0);
    check({tag, "_ram_rd"}, ram_rd, 0);
    @(posedge clk); #1 mon_en = 1'b0;
  endtask

  task automatic load_header(input int at);
    for (int i = 0; i < 8; i++) mem[at + i] = hdr_bytes[i];
  endtask

  initial begin
    logic held;
    logic [2:0] st;
    reset = 1'b1; ce_5m3 = 1'b1; play = 1'b0; rewind = 1'b0; cas_size = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cas_out", cas_out, 0);
    check("rst_ram_rd", ram_rd, 0);
    check("rst_ram_a", ram_a, 0);
    check("rst_active", active, 0);
    check("rst_state", dbg_state, S_IDLE);
    @(posedge clk); #1 reset = 1'b0;

    // header + 0x55
    load_header(0);
    mem[8] = 8'h55;
    start_image(9);
    finish_image(2000, "hdr55");

    // header, 8 data bytes, header
    load_header(0);
    for (int i = 8; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
    load_header(16);
    start_image(24);
    finish_image(5000, "hdr_data_hdr");

    // three zero bytes
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    start_image(3);
    finish_image(2000, "zeros3");
    check("zeros3_reads", rd_count, 3);

    // pause for 50 clk mid-bit
    for (int i = 0; i < 5; i++) mem[i] = 8'($urandom_range(0, 255));
    start_image(5);
    wait_state(S_SEND, 500, "pause_send");
    repeat ($urandom_range(5, 20)) @(posedge clk);
    #1 play = 1'b0;
    @(negedge clk);
    held = cas_out;
    st = dbg_state;
    repeat (50) begin
      @(negedge clk);
      check("pause_hold", cas_out, held);
    end
    check("pause_state", dbg_state, st);
    @(posedge clk); #1 play = 1'b1;
    finish_image(3000, "pause");

    // rewind mid-pilot, then replay with the long pilot
    load_header(0);
    mem[8] = 8'hA5;
    mem[9] = 8'h3C;
    start_image(10);
    wait_state(S_PILOT, 500, "rw_pilot");
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b0;
    rewind = 1'b1;
    @(posedge clk); #1 rewind = 1'b0;
    @(negedge clk);
    check("rw_ram_rd", ram_rd, 0);
    check("rw_cas_out", cas_out, 0);
    check("rw_state", dbg_state, S_IDLE);
    @(posedge clk); #1;
    build_expected(10);
    mon_en = 1'b1;
    finish_image(3000, "rw_replay");

    // reset during an outstanding read
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom_range(0, 255));
    start_image(4);
    mon_en = 1'b0;
    rd_chk = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ram_rd && ram_a == 27'd1) break;
    end
    check("rs_outstanding", ram_rd, 1);
    #1 reset = 1'b1;
    #1;
    check("rs_async_ram_rd", ram_rd, 0);
    check("rs_async_ram_a", ram_a, 0);
    play = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rs_idle", dbg_state, S_IDLE);
    check("rs_active", active, 0);
    rd_count = 0;
    cas_size = '0;
    @(posedge clk); #1 play = 1'b1;
    wait_state(S_DONE, 50, "empty_done");
    check("empty_reads", rd_count, 0);
    check("empty_ram_rd", ram_rd, 0);
    check("empty_cas_out", cas_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
